// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and elaboration-time helpers for the UART TX packet arbiter
// and its round-robin picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Ceiling log2 for sizing counters and pointers; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and TX-FIFO-side byte handshakes of the arbiter, bundled into
// one interface.
// Handshake rule for every valid/ready pair below: a byte moves on a rising
// clk edge where valid and ready are both high; valid never waits on ready.
interface uart_tx_arb_if #(
    parameter int REQ_COUNT  = 3,
    parameter int DATA_WIDTH = 8
);
    logic [REQ_COUNT-1:0]            req_valid;
    logic [REQ_COUNT*DATA_WIDTH-1:0] req_data;
    logic [REQ_COUNT-1:0]            req_last;
    logic [REQ_COUNT-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_valid;
    logic                            out_ready;

    // master: the arbiter itself; slave: the producers plus the TX FIFO.
    modport master (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_data, out_valid
    );

    modport slave (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_data, out_valid
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot of the first set request at or
// after the start pointer, scanning upward with wrap.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] start_i,
    output logic [N-1:0]  onehot_o,
    output logic          found_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        onehot_o = '0;
        found_o  = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            // start_i < N and k < N, so one conditional subtract is a full modulo.
            sum = {1'b0, start_i} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found_o && req_i[idx]) begin
                onehot_o[idx] = 1'b1;
                found_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the UART TX FIFO write port among
// several producers; forwards whole packets and truncates overlong ones.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int REQ_COUNT   = 3,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    uart_tx_arb_if.master        bus,
    output logic [REQ_COUNT-1:0] grant,
    output logic                 busy,
    output logic                 truncated,
    output arb_state_t           state_o
);

    localparam int CNT_W = clog2(MAX_PKT_LEN + 1);
    localparam int PTR_W = clog2(REQ_COUNT);

    arb_state_t           state_q, state_d;
    logic [REQ_COUNT-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 trunc_q, trunc_d;

    logic [REQ_COUNT-1:0]  pick_onehot;
    logic                  pick_found;
    logic [PTR_W-1:0]      g_idx;
    logic [PTR_W-1:0]      ptr_next;
    logic [CNT_W-1:0]      cnt_inc;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  in_xfer;
    logic                  in_drain;
    logic                  xfer_fire;
    logic                  drain_fire;

    rr_pick #(
        .N  (REQ_COUNT),
        .PW (PTR_W)
    ) u_pick (
        .req_i    (bus.req_valid),
        .start_i  (ptr_q),
        .onehot_o (pick_onehot),
        .found_o  (pick_found)
    );

    // Owner index and byte mux; both collapse to zero while grant is empty.
    always_comb begin
        g_idx    = '0;
        sel_data = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (grant_q[i]) begin
                g_idx    = PTR_W'(i);
                sel_data = sel_data | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_valid = |(bus.req_valid & grant_q);
    assign sel_last  = |(bus.req_last & grant_q);
    assign ptr_next  = (g_idx == PTR_W'(REQ_COUNT - 1)) ? '0 : g_idx + PTR_W'(1);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // ena low blanks both handshakes so nothing can move while frozen.
    assign in_xfer    = ena && (state_q == XFER);
    assign in_drain   = ena && (state_q == DRAIN);
    assign xfer_fire  = in_xfer && sel_valid && bus.out_ready;
    assign drain_fire = in_drain && sel_valid && sel_last;

    assign bus.out_data  = sel_data;
    assign bus.out_valid = in_xfer && sel_valid;
    assign bus.req_ready = ((in_xfer && bus.out_ready) || in_drain) ? grant_q : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        trunc_d = 1'b0;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_d = pick_onehot;
                        cnt_d   = '0;
                        state_d = XFER;
                    end
                end
                XFER: begin
                    if (xfer_fire) begin
                        cnt_d = cnt_inc;
                        // A last byte landing exactly on the limit is a clean end.
                        if (sel_last) begin
                            state_d = IDLE;
                            grant_d = '0;
                            ptr_d   = ptr_next;
                        end else if (cnt_inc == CNT_W'(MAX_PKT_LEN)) begin
                            trunc_d = 1'b1;
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_fire) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = ptr_next;
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign truncated = trunc_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with MAX_PKT_LEN=4: per-producer source
// queues, a byte scoreboard on the FIFO side, and hand-computed grant checks.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int DW  = 8;
    localparam int RC  = 3;
    localparam int MPL = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena   = 1'b1;
    logic [RC-1:0] grant;
    logic          busy;
    logic          truncated;
    arb_state_t    state_o;

    uart_tx_arb_if #(.REQ_COUNT(RC), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .DATA_WIDTH  (DW),
        .REQ_COUNT   (RC),
        .MAX_PKT_LEN (MPL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .bus       (bus),
        .grant     (grant),
        .busy      (busy),
        .truncated (truncated),
        .state_o   (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_xfer   = 0;
    int            n_trunc  = 0;
    logic [DW-1:0] exp_q[$];
    logic [8:0]    src0[$];
    logic [8:0]    src1[$];
    logic [8:0]    src2[$];
    logic [RC-1:0] hs = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        case (r)
            0:       src0.push_back({l, d});
            1:       src1.push_back({l, d});
            default: src2.push_back({l, d});
        endcase
    endtask

    // Consecutive bytes base..base+len-1, last flag on the final one.
    task automatic src_pkt(input int r, input logic [7:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            push_byte(r, base + 8'(k), k == len - 1);
        end
    endtask

    task automatic exp_pkt(input logic [7:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(base + 8'(k));
        end
    endtask

    task automatic pop_src(input int r);
        case (r)
            0:       void'(src0.pop_front());
            1:       void'(src1.pop_front());
            default: void'(src2.pop_front());
        endcase
    endtask

    task automatic present();
        for (int i = 0; i < RC; i++) begin
            logic [8:0] f;
            logic       has;
            has = 1'b0;
            f   = '0;
            case (i)
                0:       if (src0.size() > 0) begin has = 1'b1; f = src0[0]; end
                1:       if (src1.size() > 0) begin has = 1'b1; f = src1[0]; end
                default: if (src2.size() > 0) begin has = 1'b1; f = src2[0]; end
            endcase
            bus.req_valid[i]          = has;
            bus.req_last[i]           = f[8];
            bus.req_data[i*DW +: DW]  = f[7:0];
        end
    endtask

    function automatic logic src_pending();
        return (src0.size() + src1.size() + src2.size()) > 0;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        while ((busy || exp_q.size() > 0 || src_pending()) && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_done"}, 32'(c < budget), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Producers: retire the byte handshaken at the previous edge, show the next.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < RC; i++) begin
                if (hs[i]) pop_src(i);
            end
            present();
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            if (truncated) n_trunc++;
            if (bus.out_valid && bus.out_ready) begin
                n_xfer++;
                check("exp_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int x0;
        int t0;

        bus.out_ready = 1'b1;
        present();
        repeat (2) tick();

        check("rst_grant",     32'(grant), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_truncated", 32'(truncated), 32'd0);
        check("rst_state",     32'(state_o), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        // Single packet from requester 0.
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h0A, 1'b1);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h0A);
        present();
        check("t1_grant_pre", 32'(grant), 32'd0);
        tick();
        check("t1_grant", 32'(grant), 32'b001);
        check("t1_busy",  32'(busy), 32'd1);
        wait_done("t1", 20);
        check("t1_grant_idle", 32'(grant), 32'd0);

        // Pointer now 1: with req0 and req2 pending, req2 wins first.
        push_byte(0, 8'h50, 1'b1);
        push_byte(2, 8'h60, 1'b1);
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h50);
        present();
        tick();
        check("t2_grant", 32'(grant), 32'b100);
        wait_done("t2", 20);

        // Contention from reset: order 0,1,2 then req0's second packet.
        do_reset();
        src_pkt(0, 8'h30, 2);
        src_pkt(0, 8'h38, 2);
        src_pkt(1, 8'h70, 2);
        src_pkt(2, 8'h80, 2);
        exp_pkt(8'h30, 2);
        exp_pkt(8'h70, 2);
        exp_pkt(8'h80, 2);
        exp_pkt(8'h38, 2);
        present();
        tick();
        check("t3_grant", 32'(grant), 32'b001);
        wait_done("t3", 60);

        // Backpressure on a 4-byte packet ending exactly at the length limit.
        t0 = n_trunc;
        x0 = n_xfer;
        src_pkt(1, 8'h90, 4);
        exp_pkt(8'h90, 4);
        present();
        tick();
        check("t4_grant", 32'(grant), 32'b010);
        for (int c = 0; c < 12 && busy; c++) begin
            bus.out_ready = (c % 2 == 0);
            #1;
            check("t4_req_ready", 32'(bus.req_ready), bus.out_ready ? 32'b010 : 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_done("t4", 20);
        check("t4_xfers", 32'(n_xfer - x0), 32'd4);
        check("t4_no_trunc", 32'(n_trunc - t0), 32'd0);

        // ena low for 5 cycles after the first byte of req2's packet.
        src_pkt(2, 8'hA0, 4);
        exp_pkt(8'hA0, 4);
        present();
        tick();
        check("t5_grant", 32'(grant), 32'b100);
        tick();
        ena = 1'b0;
        x0  = n_xfer;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t5_grant_hold", 32'(grant), 32'b100);
            check("t5_out_valid",  32'(bus.out_valid), 32'd0);
            tick();
        end
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_frozen", 32'(n_xfer - x0), 32'd0);
        ena = 1'b1;
        wait_done("t5", 30);

        // Truncation: 6-byte packet, only the first 4 reach the FIFO.
        t0 = n_trunc;
        src_pkt(1, 8'hC0, 6);
        exp_pkt(8'hC0, 4);
        present();
        tick();
        check("t6_grant", 32'(grant), 32'b010);
        wait_done("t6", 30);
        check("t6_trunc_cycles", 32'(n_trunc - t0), 32'd1);
        check("t6_state", 32'(state_o), 32'(IDLE));

        // Reset during byte 2 of req2's packet; req1 waiting behind it.
        src_pkt(2, 8'hE0, 3);
        exp_q.push_back(8'hE0);
        present();
        tick();
        check("t7_grant", 32'(grant), 32'b100);
        tick();
        push_byte(1, 8'hF0, 1'b1);
        present();
        rst_n = 1'b0;
        #1;
        check("t7_rst_grant",     32'(grant), 32'd0);
        check("t7_rst_busy",      32'(busy), 32'd0);
        check("t7_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t7_rst_req_ready", 32'(bus.req_ready), 32'd0);
        exp_q.delete();
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE2);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_regrant", 32'(grant), 32'b010);
        wait_done("t7", 30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
